// File: rtl/warp_dual_issue_scheduler_pkg.sv
// Shared definitions for the warp dual-issue scheduler.
// Contents:
//   NUM_WARPS / WID_W  - warp count and encoded warp-id width
//   warp_state_e       - per-warp lifecycle state
//   grant_t            - one decode-slot grant (valid + one-hot warp)
//   wid_to_onehot      - 3-to-8 decode, also used for the SIMT writeback id
//   onehot_to_wid      - inverse of the above for a one-hot input
package warp_dual_issue_scheduler_pkg;

  localparam int NUM_WARPS = 8;
  localparam int WID_W     = 3;

  typedef enum logic [1:0] {
    W_INACTIVE = 2'b00,
    W_ACTIVE   = 2'b01,
    W_BR_WAIT  = 2'b10
  } warp_state_e;

  typedef struct packed {
    logic                 vld;
    logic [NUM_WARPS-1:0] oh;
  } grant_t;

  function automatic logic [NUM_WARPS-1:0] wid_to_onehot(input logic [WID_W-1:0] id);
    logic [NUM_WARPS-1:0] oh;
    oh     = '0;
    oh[id] = 1'b1;
    return oh;
  endfunction

  function automatic logic [WID_W-1:0] onehot_to_wid(input logic [NUM_WARPS-1:0] oh);
    logic [WID_W-1:0] id;
    id = '0;
    for (int i = 0; i < NUM_WARPS; i++)
      if (oh[i]) id = id | WID_W'(i);
    return id;
  endfunction

endpackage

// File: rtl/warp_dual_issue_scheduler_rr_dual_pick.sv
// Combinational round-robin dual picker.
// Ports:
//   elig_i  - eligible warp mask
//   ptr_i   - round-robin start position
//   pick0_o - one-hot first eligible warp at or after ptr_i (wrapping), 0 if none
//   pick1_o - one-hot next eligible warp after pick0_o in the same scan, 0 if none
//   vld0_o / vld1_o - pick valids
module warp_dual_issue_scheduler_rr_dual_pick
  import warp_dual_issue_scheduler_pkg::*;
(
  input  logic [NUM_WARPS-1:0] elig_i,
  input  logic [WID_W-1:0]     ptr_i,
  output logic [NUM_WARPS-1:0] pick0_o,
  output logic [NUM_WARPS-1:0] pick1_o,
  output logic                 vld0_o,
  output logic                 vld1_o
);

  logic [2*NUM_WARPS-1:0] rot_dbl, back0_dbl, back1_dbl;
  logic [NUM_WARPS-1:0]   rot, rem, r0, r1;

  always_comb begin
    // rotate so that bit 0 is the warp at ptr_i
    rot_dbl   = {elig_i, elig_i} >> ptr_i;
    rot       = rot_dbl[NUM_WARPS-1:0];
    // x & -x isolates the lowest set bit: two cascaded priority encoders
    r0        = rot & (~rot + NUM_WARPS'(1));
    rem       = rot & ~r0;
    r1        = rem & (~rem + NUM_WARPS'(1));
    // rotate back; the upper half of the doubled word holds the wrapped result
    back0_dbl = {r0, r0} << ptr_i;
    back1_dbl = {r1, r1} << ptr_i;
    pick0_o   = back0_dbl[2*NUM_WARPS-1:NUM_WARPS];
    pick1_o   = back1_dbl[2*NUM_WARPS-1:NUM_WARPS];
    vld0_o    = |rot;
    vld1_o    = |rem;
  end

endmodule

// File: rtl/warp_dual_issue_scheduler.sv
// Per-cycle warp selector for the two decode slots (ID0/ID1).
// Ports:
//   clk, rst_n          - clock, synchronous active-low reset
//   Warp_Start          - per-warp launch pulse (INACTIVE -> ACTIVE)
//   IB_Valid / IB_Head_* - instruction-buffer head status per warp
//   SIMT_Full / SIMT_TwoMoreVacant - SIMT stack room per warp
//   WB_Update_SIMT / WarpID_from_WB - branch resolve from writeback
//   ID_Stall            - decode not accepting; grants hold
//   Grant_Valid0/1, Grant_WarpID0/1 - registered slot grants (one-hot)
//   Warp_Active         - warp not INACTIVE
//   All_Done            - no active warp and no outstanding grant
module warp_dual_issue_scheduler
  import warp_dual_issue_scheduler_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_WARPS-1:0] Warp_Start,
  input  logic [NUM_WARPS-1:0] IB_Valid,
  input  logic [NUM_WARPS-1:0] IB_Head_Branch,
  input  logic [NUM_WARPS-1:0] IB_Head_Call,
  input  logic [NUM_WARPS-1:0] IB_Head_Exit,
  input  logic [NUM_WARPS-1:0] SIMT_Full,
  input  logic [NUM_WARPS-1:0] SIMT_TwoMoreVacant,
  input  logic                 WB_Update_SIMT,
  input  logic [WID_W-1:0]     WarpID_from_WB,
  input  logic                 ID_Stall,
  output logic                 Grant_Valid0,
  output logic [NUM_WARPS-1:0] Grant_WarpID0,
  output logic                 Grant_Valid1,
  output logic [NUM_WARPS-1:0] Grant_WarpID1,
  output logic [NUM_WARPS-1:0] Warp_Active,
  output logic                 All_Done
);

  grant_t               g0_q, g1_q;
  logic [WID_W-1:0]     rr_q, rr_d, last_wid;
  logic [NUM_WARPS-1:0] cool_q, cool_d, gmask_q, wb_oh, elig, pick0, pick1;
  logic                 pv0, pv1, accept;

  assign accept   = !ID_Stall;
  assign gmask_q  = g0_q.oh | g1_q.oh;
  assign wb_oh    = WB_Update_SIMT ? wid_to_onehot(WarpID_from_WB) : '0;
  // slot 1 is always later in the scan than slot 0, so it is the last granted
  assign last_wid = onehot_to_wid(g1_q.vld ? g1_q.oh : g0_q.oh);
  // The selection made at an accepting edge already uses the updated pointer
  // and excludes the grants being accepted at that same edge; otherwise a
  // warp could be re-issued before its state transition has landed.
  assign rr_d     = (accept && g0_q.vld) ? last_wid + WID_W'(1) : rr_q;
  assign cool_d   = accept ? gmask_q : cool_q;

  for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
    warp_state_e st_q;

    assign elig[w] = (st_q == W_ACTIVE) && IB_Valid[w] && !cool_d[w]
                   && (!IB_Head_Branch[w] || SIMT_TwoMoreVacant[w])
                   && (!IB_Head_Call[w]   || !SIMT_Full[w]);
    assign Warp_Active[w] = (st_q != W_INACTIVE);

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        st_q <= W_INACTIVE;
      end else begin
        case (st_q)
          W_INACTIVE: if (Warp_Start[w]) st_q <= W_ACTIVE;
          W_ACTIVE: begin
            if (accept && gmask_q[w]) begin
              if (IB_Head_Exit[w])        st_q <= W_INACTIVE;
              else if (IB_Head_Branch[w]) st_q <= W_BR_WAIT;
            end
          end
          W_BR_WAIT:  if (wb_oh[w]) st_q <= W_ACTIVE;
          default:    st_q <= W_INACTIVE;
        endcase
      end
    end
  end

  warp_dual_issue_scheduler_rr_dual_pick u_pick (
    .elig_i  (elig),
    .ptr_i   (rr_d),
    .pick0_o (pick0),
    .pick1_o (pick1),
    .vld0_o  (pv0),
    .vld1_o  (pv1)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      g0_q   <= '0;
      g1_q   <= '0;
      rr_q   <= '0;
      cool_q <= '0;
    end else if (accept) begin
      g0_q   <= '{vld: pv0, oh: pick0};
      g1_q   <= '{vld: pv1, oh: pick1};
      rr_q   <= rr_d;
      cool_q <= cool_d;
    end
  end

  assign Grant_Valid0  = g0_q.vld;
  assign Grant_WarpID0 = g0_q.oh;
  assign Grant_Valid1  = g1_q.vld;
  assign Grant_WarpID1 = g1_q.oh;
  assign All_Done      = ~|Warp_Active & ~g0_q.vld & ~g1_q.vld;

endmodule

// File: tb/tb_warp_dual_issue_scheduler.sv
module tb_warp_dual_issue_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] Warp_Start, IB_Valid, IB_Head_Branch, IB_Head_Call, IB_Head_Exit;
  logic [7:0] SIMT_Full, SIMT_TwoMoreVacant;
  logic       WB_Update_SIMT;
  logic [2:0] WarpID_from_WB;
  logic       ID_Stall;
  logic       Grant_Valid0, Grant_Valid1, All_Done;
  logic [7:0] Grant_WarpID0, Grant_WarpID1, Warp_Active;

  warp_dual_issue_scheduler dut (
    .clk(clk), .rst_n(rst_n), .Warp_Start(Warp_Start), .IB_Valid(IB_Valid),
    .IB_Head_Branch(IB_Head_Branch), .IB_Head_Call(IB_Head_Call),
    .IB_Head_Exit(IB_Head_Exit), .SIMT_Full(SIMT_Full),
    .SIMT_TwoMoreVacant(SIMT_TwoMoreVacant), .WB_Update_SIMT(WB_Update_SIMT),
    .WarpID_from_WB(WarpID_from_WB), .ID_Stall(ID_Stall),
    .Grant_Valid0(Grant_Valid0), .Grant_WarpID0(Grant_WarpID0),
    .Grant_Valid1(Grant_Valid1), .Grant_WarpID1(Grant_WarpID1),
    .Warp_Active(Warp_Active), .All_Done(All_Done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: warp life (0 idle, 1 running, 2 waiting on branch),
  // outstanding slot grants as warp numbers (-1 = none), scan start.
  int m_st[8];
  int m_g0 = -1, m_g1 = -1, m_rr = 0;

  task automatic model_edge();
    int ns[8];
    int n0, n1, w;
    bit ok;
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) m_st[i] = 0;
      m_g0 = -1; m_g1 = -1; m_rr = 0;
      return;
    end
    for (int i = 0; i < 8; i++) begin
      ns[i] = m_st[i];
      if (m_st[i] == 0 && Warp_Start[i]) ns[i] = 1;
      if (m_st[i] == 2 && WB_Update_SIMT && int'(WarpID_from_WB) == i) ns[i] = 1;
    end
    if (!ID_Stall) begin
      if (m_g0 >= 0) begin
        if (IB_Head_Exit[m_g0]) ns[m_g0] = 0; else if (IB_Head_Branch[m_g0]) ns[m_g0] = 2;
      end
      if (m_g1 >= 0) begin
        if (IB_Head_Exit[m_g1]) ns[m_g1] = 0; else if (IB_Head_Branch[m_g1]) ns[m_g1] = 2;
      end
      if (m_g0 >= 0) m_rr = (((m_g1 >= 0) ? m_g1 : m_g0) + 1) % 8;
      n0 = -1; n1 = -1;
      for (int k = 0; k < 8; k++) begin
        w  = (m_rr + k) % 8;
        ok = (m_st[w] == 1) && IB_Valid[w] && (w != m_g0) && (w != m_g1)
             && (!IB_Head_Branch[w] || SIMT_TwoMoreVacant[w])
             && (!IB_Head_Call[w] || !SIMT_Full[w]);
        if (ok) begin
          if (n0 < 0) n0 = w;
          else if (n1 < 0) n1 = w;
        end
      end
      m_g0 = n0; m_g1 = n1;
    end
    for (int i = 0; i < 8; i++) m_st[i] = ns[i];
  endtask

  function automatic logic [26:0] exp_vec();
    logic [7:0] act;
    act = '0;
    for (int i = 0; i < 8; i++) if (m_st[i] != 0) act[i] = 1'b1;
    return {m_g0 >= 0, (m_g0 >= 0) ? 8'(1 << m_g0) : 8'h00,
            m_g1 >= 0, (m_g1 >= 0) ? 8'(1 << m_g1) : 8'h00,
            act, (act == 0) && (m_g0 < 0) && (m_g1 < 0)};
  endfunction

  function automatic logic [26:0] got_vec();
    return {Grant_Valid0, Grant_WarpID0, Grant_Valid1, Grant_WarpID1, Warp_Active, All_Done};
  endfunction

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_defaults();
    Warp_Start = 0; IB_Valid = 8'hFF; IB_Head_Branch = 0; IB_Head_Call = 0;
    IB_Head_Exit = 0; SIMT_Full = 0; SIMT_TwoMoreVacant = 8'hFF;
    WB_Update_SIMT = 0; WarpID_from_WB = 0; ID_Stall = 0;
  endtask

  task automatic restart();
    set_defaults();
    rst_n = 0; tick(); rst_n = 1;
  endtask

  task automatic test_reset();
    set_defaults();
    rst_n = 0; tick(); tick(); rst_n = 1;
    n_cmp++;
    if (got_vec() !== exp_vec() || Warp_Active !== 8'h00 || All_Done !== 1'b1 ||
        Grant_Valid0 !== 1'b0 || Grant_Valid1 !== 1'b0) begin
      n_bad++; $display("FAIL reset: got %h need %h", got_vec(), exp_vec());
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] e0 [5] = '{8'h01, 8'h04, 8'h10, 8'h40, 8'h01};
    logic [7:0] e1 [5] = '{8'h02, 8'h08, 8'h20, 8'h80, 8'h02};
    restart();
    Warp_Start = 8'hFF; tick(); Warp_Start = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (got_vec() !== exp_vec() || Grant_WarpID0 !== e0[i] || Grant_WarpID1 !== e1[i]) begin
        n_bad++;
        $display("FAIL rr step%0d: got %h/%h need %h/%h", i, Grant_WarpID0, Grant_WarpID1, e0[i], e1[i]);
      end
    end
  endtask

  task automatic test_branch_gate();
    int seen;
    restart();
    IB_Head_Branch = 8'h08; SIMT_TwoMoreVacant = 8'hF7;
    Warp_Start = 8'hFF; tick(); Warp_Start = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++;
      if (got_vec() !== exp_vec() || ((Grant_WarpID0 | Grant_WarpID1) & 8'h08) != 0) begin
        n_bad++; $display("FAIL br_gated c%0d: got %h need %h", i, got_vec(), exp_vec());
      end
    end
    SIMT_TwoMoreVacant = 8'hFF;
    seen = 0;
    for (int i = 0; i < 10 && seen == 0; i++) begin
      tick();
      if (((Grant_WarpID0 | Grant_WarpID1) & 8'h08) != 0) seen = 1;
    end
    n_cmp++;
    if (seen != 1 || got_vec() !== exp_vec()) begin
      n_bad++; $display("FAIL br_grant: seen %0d got %h need %h", seen, got_vec(), exp_vec());
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++;
      if (got_vec() !== exp_vec() || ((Grant_WarpID0 | Grant_WarpID1) & 8'h08) != 0) begin
        n_bad++; $display("FAIL br_wait c%0d: got %h need %h", i, got_vec(), exp_vec());
      end
    end
    WB_Update_SIMT = 1; WarpID_from_WB = 3; tick(); WB_Update_SIMT = 0;
    seen = 0;
    for (int i = 0; i < 10 && seen == 0; i++) begin
      tick();
      n_cmp++;
      if (got_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL br_resolve c%0d: got %h need %h", i, got_vec(), exp_vec());
      end
      if (((Grant_WarpID0 | Grant_WarpID1) & 8'h08) != 0) seen = 1;
    end
    n_cmp++;
    if (seen != 1) begin
      n_bad++; $display("FAIL br_regrant: seen %0d need 1", seen);
    end
  endtask

  task automatic test_call_gate();
    restart();
    IB_Valid = 8'h20; IB_Head_Call = 8'h20; SIMT_Full = 8'h20;
    Warp_Start = 8'hFF; tick(); Warp_Start = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (got_vec() !== exp_vec() || Grant_Valid0 !== 1'b0 || Grant_Valid1 !== 1'b0) begin
        n_bad++; $display("FAIL call_full c%0d: got %h need %h", i, got_vec(), exp_vec());
      end
    end
    SIMT_Full = 0; tick();
    n_cmp++;
    if (got_vec() !== exp_vec() || Grant_Valid0 !== 1'b1 || Grant_WarpID0 !== 8'h20 ||
        Grant_Valid1 !== 1'b0 || Grant_WarpID1 !== 8'h00) begin
      n_bad++; $display("FAIL call_grant: got %h need %h", got_vec(), exp_vec());
    end
  endtask

  task automatic test_stall();
    restart();
    IB_Valid = 8'hFD;
    Warp_Start = 8'hFF; tick(); Warp_Start = 0;
    tick();
    ID_Stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (got_vec() !== exp_vec() || Grant_WarpID0 !== 8'h01 || Grant_WarpID1 !== 8'h04) begin
        n_bad++; $display("FAIL stall_hold c%0d: got %h/%h need 01/04", i, Grant_WarpID0, Grant_WarpID1);
      end
    end
    ID_Stall = 0; tick();
    n_cmp++;
    if (got_vec() !== exp_vec() || Grant_WarpID0 !== 8'h08 || Grant_WarpID1 !== 8'h10) begin
      n_bad++; $display("FAIL stall_release: got %h/%h need 08/10", Grant_WarpID0, Grant_WarpID1);
    end
  endtask

  task automatic test_exit_done();
    int n;
    restart();
    IB_Head_Exit = 8'hFF;
    Warp_Start = 8'hFF; tick(); Warp_Start = 0;
    tick(); tick();
    n_cmp++;
    if (got_vec() !== exp_vec() || Warp_Active !== 8'hFC) begin
      n_bad++; $display("FAIL exit01: active %h need fc", Warp_Active);
    end
    n = 0;
    while (All_Done !== 1'b1 && n < 10) begin
      tick(); n++;
      n_cmp++;
      if (got_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL exit_run c%0d: got %h need %h", n, got_vec(), exp_vec());
      end
    end
    n_cmp++;
    if (All_Done !== 1'b1 || Warp_Active !== 8'h00) begin
      n_bad++; $display("FAIL all_done: done %b active %h need 1/00", All_Done, Warp_Active);
    end
  endtask

  task automatic test_reset_midop();
    restart();
    IB_Head_Branch = 8'h04;
    Warp_Start = 8'hFF; tick(); Warp_Start = 0;
    tick(); tick(); tick();
    n_cmp++;
    if (got_vec() !== exp_vec() || Grant_Valid0 !== 1'b1 || m_st[2] != 2) begin
      n_bad++; $display("FAIL midop_setup: got %h need %h", got_vec(), exp_vec());
    end
    rst_n = 0; tick(); rst_n = 1;
    n_cmp++;
    if (got_vec() !== exp_vec() || Grant_Valid0 !== 1'b0 || Grant_Valid1 !== 1'b0 ||
        Warp_Active !== 8'h00 || All_Done !== 1'b1) begin
      n_bad++; $display("FAIL midop_reset: got %h need %h", got_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    restart();
    for (int c = 0; c < 400; c++) begin
      Warp_Start         = 8'($urandom) & 8'($urandom) & 8'($urandom);
      IB_Valid           = 8'($urandom) | 8'($urandom);
      IB_Head_Branch     = 8'($urandom) & 8'($urandom);
      IB_Head_Call       = 8'($urandom) & 8'($urandom);
      IB_Head_Exit       = 8'($urandom) & 8'($urandom) & 8'($urandom);
      SIMT_Full          = 8'($urandom) & 8'($urandom);
      SIMT_TwoMoreVacant = 8'($urandom) | 8'($urandom);
      WB_Update_SIMT     = ($urandom_range(0, 2) != 0);
      WarpID_from_WB     = 3'($urandom_range(0, 7));
      ID_Stall           = ($urandom_range(0, 3) == 0);
      tick();
      n_cmp++;
      if (got_vec() !== exp_vec() || (Grant_WarpID0 & Grant_WarpID1) != 0) begin
        n_bad++; $display("FAIL random c%0d: got %h need %h", c, got_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_branch_gate();
    test_call_gate();
    test_stall();
    test_exit_done();
    test_reset_midop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/warp_dual_issue_scheduler.md
Name: warp_dual_issue_scheduler

Overview:
- Per-cycle warp selector feeding the two decode slots (ID0/ID1) that drive the SIMT reconvergence stack.
- Tracks a lifecycle state for each of 8 warps and picks up to two eligible warps per cycle using round-robin.
- Gates any warp whose head instruction would push onto a SIMT stack that lacks room.
- Holds a warp with an in-flight branch until writeback resolves it.

Parameters:
- NUM_WARPS, 8, number of warps; one-hot grant width.
- WID_W, 3, encoded warp-id width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock; reset is synchronous and active-low.
- Warp_Start  in  8  pulse per warp: launch warp (INACTIVE->ACTIVE).
- IB_Valid  in  8  instruction buffer holds a decodable head instruction for warp i.
- IB_Head_Branch  in  8  head instruction of warp i is a branch.
- IB_Head_Call  in  8  head instruction of warp i is a call.
- IB_Head_Exit  in  8  head instruction of warp i is exit.
- SIMT_Full  in  8  SIMT stack of warp i is full.
- SIMT_TwoMoreVacant  in  8  SIMT stack of warp i has >=2 free entries.
- WB_Update_SIMT  in  1  writeback resolves a branch.
- WarpID_from_WB  in  3  warp id of the resolving branch.
- ID_Stall  in  1  decode cannot accept new grants this cycle.
- Grant_Valid0  out  1  slot 0 grant valid.
- Grant_WarpID0  out  8  one-hot warp for ID0; zero when invalid.
- Grant_Valid1  out  1  slot 1 grant valid.
- Grant_WarpID1  out  8  one-hot warp for ID1; zero when invalid.
- Warp_Active  out  8  warp i is not INACTIVE.
- All_Done  out  1  all warps INACTIVE and no grant outstanding.

Behaviour:
- Reset (rst_n low at a clk edge):
  - all warps go INACTIVE, grants go to 0, the rr pointer goes to 0 and the cooldown mask clears.
  - Warp_Active is 0 and All_Done is 1 after reset.
  - Reset mid-operation discards in-flight grants.
- Per-warp FSM, 2-bit state:
  - INACTIVE -> ACTIVE on Warp_Start[i]. Warp_Start on a non-INACTIVE warp is ignored.
  - ACTIVE -> BR_WAIT when a grant to warp i is accepted with IB_Head_Branch[i]=1.
  - ACTIVE -> INACTIVE when a grant is accepted with IB_Head_Exit[i]=1.
  - BR_WAIT -> ACTIVE on WB_Update_SIMT with WarpID_from_WB==i.
  - WB_Update_SIMT naming a warp not in BR_WAIT has no effect.
- Acceptance: a registered grant is accepted at the rising edge at which ID_Stall=0.
- Eligibility of warp i: all of the following hold.
  - state is ACTIVE and IB_Valid[i]=1.
  - i is not in the cooldown mask.
  - if the head is a branch, SIMT_TwoMoreVacant[i]=1 (ID push plus possible WB DIV push).
  - if the head is a call, SIMT_Full[i]=0.
- Selection and grant latency:
  - slot 0 takes the first eligible warp scanning from rr_ptr upward, wrapping modulo 8.
  - slot 1 takes the next eligible warp after slot 0 in the same scan.
  - a single eligible warp always goes to slot 0.
  - grants are registered: eligibility sampled at edge N appears on the outputs after edge N.
- Stall:
  - while ID_Stall=1, grant registers, rr_ptr, cooldown and FSM transitions caused by grants all hold.
  - WB and Warp_Start transitions still occur during stall.
- On acceptance:
  - rr_ptr becomes (last granted id + 1) mod 8.
  - cooldown becomes the accepted grant mask, so a just-issued warp is excluded for exactly one selection.
  - with no grants, rr_ptr is unchanged.
- Simultaneous events:
  - a WB resolve and a Warp_Start on different warps are both applied.
  - a WB resolve cannot coincide with a grant to the same warp (BR_WAIT is ineligible).
- All_Done is 1 when Warp_Active==0 and both Grant_Valid are 0.
- Invariant: Grant_WarpID0 & Grant_WarpID1 == 0 always.

Decomposition:
- Shared package holds:
  - warp state encoding: INACTIVE=2'b00, ACTIVE=2'b01, BR_WAIT=2'b10.
  - NUM_WARPS and WID_W.
  - a 3-to-8 one-hot decode function (shared with the SIMT WB decode).
- One sub-module is natural: rr_dual_pick.
  - purely combinational: 8-bit eligible mask plus 3-bit pointer in, two one-hot picks plus valids out.
  - built by rotate, two priority-encode stages, then rotate back.

Test Plan:
- Reset then Warp_Start=8'hFF with IB_Valid=8'hFF and no control-flow heads -> first grants 0x01/0x02, then 0x04/0x08, 0x10/0x20, 0x40/0x80, then wrap to 0x01/0x02.
- Warp 3 head is a branch with SIMT_TwoMoreVacant[3]=0 -> warp 3 is never granted. Set the bit to 1 -> warp 3 is granted, enters BR_WAIT and stays ungranted until WB_Update_SIMT=1 with WarpID_from_WB=3.
- Only warp 5 is eligible and its head is a call with SIMT_Full[5]=1 -> no grants. Clear Full -> Grant_Valid0=1 with Grant_WarpID0=0x20 and Grant_Valid1=0.
- ID_Stall=1 for 3 cycles with grants 0x01/0x04 -> the outputs hold 0x01/0x04 and rr_ptr is unchanged. Stall drops -> next grants start from warp 3.
- Warps 0 and 1 accept exits -> Warp_Active clears bits 0 and 1. When all 8 warps have exited, All_Done=1.
- Assert rst_n=0 while grants are valid and warp 2 is in BR_WAIT -> next cycle all grants are 0, Warp_Active=0 and All_Done=1.
